// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - credit-limited in-order instruction fetch with redirect flush
module inst_fetch #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic        o_id_valid,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    input  logic        i_id_ready
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   pcf_mem [DEPTH];
    logic [AW-1:0] pcf_wr;
    logic [AW-1:0] pcf_rd;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_inst  [DEPTH];
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;
    logic [CW-1:0] q_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW:0]   credit_used;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          q_pop;

    // Every outstanding request already owns a queue slot, so the queue can never overflow.
    assign credit_used      = {1'b0, r_inflight} + {1'b0, q_count};
    assign credit_ok        = credit_used < (CW + 1)'(DEPTH);
    assign o_imem_req_valid = i_reset & ~i_redirect & credit_ok;
    assign o_imem_req_addr  = r_pc;

    assign req_fire = o_imem_req_valid & i_imem_req_ready;
    assign rsp_fire = i_imem_rsp_valid & (r_inflight != '0);
    assign rsp_keep = rsp_fire & (r_drop == '0) & ~i_redirect;
    assign q_pop    = (q_count != '0) & i_id_ready & ~i_redirect;

    assign o_id_valid = (q_count != '0);
    assign o_id_pc    = o_id_valid ? q_pc[q_rd]   : 32'h0;
    assign o_id_inst  = o_id_valid ? q_inst[q_rd] : 32'h0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pc       <= RESET_PC;
            pcf_wr     <= '0;
            pcf_rd     <= '0;
            q_wr       <= '0;
            q_rd       <= '0;
            q_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
        end else begin
            if (i_redirect) begin
                r_pc <= i_redirect_pc & ~32'h3;
            end else if (req_fire) begin
                r_pc <= r_pc + 32'd4;
            end

            if (req_fire) begin
                pcf_wr <= pcf_wr + AW'(1);
            end
            if (rsp_fire) begin
                pcf_rd <= pcf_rd + AW'(1);
            end
            r_inflight <= r_inflight + CW'(req_fire) - CW'(rsp_fire);

            // Everything still outstanding after a redirect belongs to the old path.
            if (i_redirect) begin
                r_drop <= r_inflight - CW'(rsp_fire);
            end else if (rsp_fire && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end

            if (i_redirect) begin
                q_rd    <= q_wr;
                q_count <= '0;
            end else begin
                if (rsp_keep) begin
                    q_wr <= q_wr + AW'(1);
                end
                if (q_pop) begin
                    q_rd <= q_rd + AW'(1);
                end
                q_count <= q_count + CW'(rsp_keep) - CW'(q_pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            pcf_mem[pcf_wr] <= r_pc;
        end
        if (rsp_keep) begin
            q_pc[q_wr]   <= pcf_mem[pcf_rd];
            q_inst[q_wr] <= i_imem_rsp_data;
        end
    end

    a_no_queue_overflow: assert property (@(posedge i_clk) disable iff (!i_reset)
        !(rsp_keep && (q_count == CW'(DEPTH))));

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - randomized and directed check of inst_fetch against a queue model
module tb_inst_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] XORK     = 32'hA5A5_0000;

    logic        i_clk;
    logic        i_reset;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_inst;
    logic        i_id_ready;

    inst_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc),
        .o_imem_req_valid (o_imem_req_valid),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_req_ready (i_imem_req_ready),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_id_valid       (o_id_valid),
        .o_id_pc          (o_id_pc),
        .o_id_inst        (o_id_inst),
        .i_id_ready       (i_id_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] pc; bit stale; } infl_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    infl_t       m_infl[$];
    ent_t        m_q[$];
    mreq_t       mem[$];
    logic [31:0] popped[$];
    logic [31:0] m_pc;
    int          cyc;
    int          lat_max;
    int          hs_count;
    bit          stray;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic redir, input logic [31:0] rpc, input logic rdy,
                        input logic rsp_en, input logic pop);
        bit          stray_now, exp_rv, hs, rspf, popf;
        logic [31:0] req_addr;
        infl_t       e;
        i_redirect       = redir;
        i_redirect_pc    = rpc;
        i_imem_req_ready = rdy;
        i_id_ready       = pop;
        if (stray) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = $urandom;
        end else if (rsp_en && mem.size() > 0 && mem[0].due <= cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem[0].addr ^ XORK;
        end else begin
            i_imem_rsp_valid = 1'b0;
            i_imem_rsp_data  = $urandom;
        end
        stray_now = stray;
        stray     = 1'b0;
        #1;
        exp_rv = i_reset && !redir && (m_infl.size() + m_q.size() < DEPTH);
        chk("req_valid", {31'b0, o_imem_req_valid}, {31'b0, exp_rv});
        chk("req_addr", o_imem_req_addr, m_pc);
        chk("id_valid", {31'b0, o_id_valid}, (m_q.size() > 0) ? 32'h1 : 32'h0);
        chk("id_pc", o_id_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
        chk("id_inst", o_id_inst, (m_q.size() > 0) ? m_q[0].inst : 32'h0);
        hs       = exp_rv && rdy;
        rspf     = i_imem_rsp_valid && (m_infl.size() > 0);
        popf     = (m_q.size() > 0) && pop && !redir;
        req_addr = m_pc;
        @(posedge i_clk);
        if (popf) begin
            popped.push_back(m_q[0].pc);
            void'(m_q.pop_front());
        end
        if (rspf) begin
            e = m_infl.pop_front();
            if (!e.stale && !redir) m_q.push_back('{e.pc, i_imem_rsp_data});
        end
        if (redir) begin
            m_q.delete();
            foreach (m_infl[k]) m_infl[k].stale = 1'b1;
            m_pc = rpc & ~32'h3;
        end else if (hs) begin
            m_infl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
            hs_count++;
        end
        if (i_imem_rsp_valid && !stray_now && mem.size() > 0) void'(mem.pop_front());
        if (hs) mem.push_back('{req_addr, cyc + 1 + $urandom_range(0, lat_max - 1)});
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        i_reset          = 1'b0;
        i_redirect       = 1'b0;
        i_imem_req_ready = 1'b1;
        i_imem_rsp_valid = 1'b1;
        #1;
        chk("rst_req_valid", {31'b0, o_imem_req_valid}, 32'h0);
        chk("rst_req_addr", o_imem_req_addr, RESET_PC);
        chk("rst_id_valid", {31'b0, o_id_valid}, 32'h0);
        chk("rst_id_pc", o_id_pc, 32'h0);
        chk("rst_id_inst", o_id_inst, 32'h0);
        m_infl.delete();
        m_q.delete();
        mem.delete();
        m_pc = RESET_PC;
        @(posedge i_clk);
        #1;
        chk("rst_hold_valid", {31'b0, o_imem_req_valid}, 32'h0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        stray   = 1'b1;
    endtask

    task automatic rnd(input int n, input int rdy_pct, input int rsp_pct,
                       input int pop_pct, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            tick($urandom_range(99) < redir_pct, $urandom, $urandom_range(99) < rdy_pct,
                 $urandom_range(99) < rsp_pct, $urandom_range(99) < pop_pct);
        end
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; lat_max = 1; hs_count = 0; stray = 1'b0;
        i_reset = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
        i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = 32'h0;
        i_id_ready = 1'b0;
        m_pc = RESET_PC;

        // streaming: first delivery two cycles after the first request
        do_reset();
        popped.delete();
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("first_valid", {31'b0, o_id_valid}, 32'h1);
        chk("first_pc", o_id_pc, 32'h0);
        chk("first_inst", o_id_inst, XORK);
        repeat (10) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("stream_any", (popped.size() > 0) ? 32'h1 : 32'h0, 32'h1);
        foreach (popped[k]) chk("stream_order", popped[k], 32'(k) * 32'd4);

        // decode backpressure: credit caps outstanding work at DEPTH
        do_reset();
        hs_count = 0;
        repeat (6) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("bp_reqs", 32'(hs_count), 32'd2);
        chk("bp_valid", {31'b0, o_imem_req_valid}, 32'h0);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("bp_resume_valid", {31'b0, o_imem_req_valid}, 32'h1);
        chk("bp_resume_addr", o_imem_req_addr, 32'h8);

        // memory stall: request held stable
        do_reset();
        repeat (5) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
            chk("stall_valid", {31'b0, o_imem_req_valid}, 32'h1);
            chk("stall_addr", o_imem_req_addr, 32'h0);
        end
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("stall_next", o_imem_req_addr, 32'h4);

        // redirect with two requests outstanding
        do_reset();
        tick(1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        chk("rd_inflight", 32'(m_infl.size()), 32'd2);
        tick(1'b1, 32'h103, 1'b1, 1'b0, 1'b1);
        chk("rd_flush", {31'b0, o_id_valid}, 32'h0);
        repeat (8) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("rd_target_valid", {31'b0, o_id_valid}, 32'h1);
        chk("rd_target_pc", o_id_pc, 32'h100);
        chk("rd_target_inst", o_id_inst, 32'h100 ^ XORK);

        // redirect coinciding with a response and a decode pop
        do_reset();
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rr_setup_valid", {31'b0, o_id_valid}, 32'h1);
        tick(1'b1, 32'h200, 1'b1, 1'b1, 1'b1);
        chk("rr_empty", {31'b0, o_id_valid}, 32'h0);
        popped.delete();
        repeat (6) tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rr_got", (popped.size() > 0) ? 32'h1 : 32'h0, 32'h1);
        if (popped.size() > 0) chk("rr_first_pc", popped[0], 32'h200);

        // asynchronous reset with requests in flight
        do_reset();
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        #2;
        do_reset();
        tick(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        chk("rst_restart_addr", o_imem_req_addr, RESET_PC + 32'd4);

        // randomized traffic
        lat_max = 3;
        rnd(2000, 70, 70, 60, 5);
        do_reset();
        rnd(1000, 90, 90, 90, 2);
        rnd(1000, 50, 50, 30, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
